// File: rtl/robot_pkg.sv
// Shared types and constants for the wall-following robot datapath.
package robot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    TURN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] HEAD_N = 2'd0;
  localparam logic [1:0] HEAD_E = 2'd1;
  localparam logic [1:0] HEAD_S = 2'd2;
  localparam logic [1:0] HEAD_W = 2'd3;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef struct packed {
    logic left_en;
    logic left_dir;
    logic right_en;
    logic right_dir;
  } motor_t;

endpackage

// File: rtl/motor_sequencer_if.sv
// Command/status bundle between the controller and the motor sequencer.
interface motor_sequencer_if;
  logic       front;
  logic       turn;
  logic       ready;
  logic       busy;
  logic       done;
  logic       left_en;
  logic       left_dir;
  logic       right_en;
  logic       right_dir;
  logic [1:0] heading;
  logic [7:0] move_count;

  modport master (
    output front, turn,
    input  ready, busy, done, left_en, left_dir, right_en, right_dir,
           heading, move_count
  );

  modport slave (
    input  front, turn,
    output ready, busy, done, left_en, left_dir, right_en, right_dir,
           heading, move_count
  );
endinterface

// File: rtl/duration_counter.sv
// Loadable down-counter that times how long the motors stay driven.
module duration_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  // zero is kept as a register so it follows count_q without a compare on the output path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      zero    <= 1'b1;
    end else if (load) begin
      count_q <= load_value;
      zero    <= (load_value == '0);
    end else if (dec) begin
      count_q <= count_q - CNT_W'(1);
      zero    <= (count_q == CNT_W'(1));
    end
  end

endmodule

// File: rtl/motor_sequencer.sv
// Turns accepted front/turn commands into timed differential-drive sequences
// and tracks heading and completed forward moves.
module motor_sequencer
  import robot_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned TURN_CYCLES = 3,
  parameter int unsigned CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  motor_sequencer_if.slave   bus
);

  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  if (STEP_CYCLES < 1 || STEP_CYCLES > CNT_MAX) begin : g_bad_step
    $error("motor_sequencer: STEP_CYCLES out of range for CNT_W");
  end
  if (TURN_CYCLES < 1 || TURN_CYCLES > CNT_MAX) begin : g_bad_turn
    $error("motor_sequencer: TURN_CYCLES out of range for CNT_W");
  end

  state_t           state_q, state_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_value;

  motor_t           motor_q, motor_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       heading_q;
  logic [7:0]       move_count_q;

  duration_counter #(.CNT_W(CNT_W)) u_duration (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // State register; outputs are registered from the decode of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      motor_q      <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      heading_q    <= HEAD_N;
      move_count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      motor_q <= motor_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (state_q == TURN && state_d == DONE) heading_q <= heading_q + 2'd1;
      if (state_q == FWD && state_d == DONE)  move_count_q <= move_count_q + 8'd1;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_value = '0;
    case (state_q)
      IDLE: begin
        if (bus.turn) begin
          state_d   = TURN;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(TURN_CYCLES - 1);
        end else if (bus.front) begin
          state_d   = FWD;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(STEP_CYCLES - 1);
        end
      end
      FWD, TURN: begin
        if (cnt_zero) state_d = DONE;
        else          cnt_dec = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode of the state being entered
  always_comb begin
    motor_d = '0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      IDLE: ready_d = 1'b1;
      FWD: begin
        busy_d            = 1'b1;
        motor_d.left_en   = 1'b1;
        motor_d.left_dir  = DIR_FWD;
        motor_d.right_en  = 1'b1;
        motor_d.right_dir = DIR_FWD;
      end
      TURN: begin
        busy_d            = 1'b1;
        motor_d.left_en   = 1'b1;
        motor_d.left_dir  = DIR_FWD;
        motor_d.right_en  = 1'b1;
        motor_d.right_dir = DIR_REV;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.left_en    = motor_q.left_en;
  assign bus.left_dir   = motor_q.left_dir;
  assign bus.right_en   = motor_q.right_en;
  assign bus.right_dir  = motor_q.right_dir;
  assign bus.heading    = heading_q;
  assign bus.move_count = move_count_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// Self-checking bench for motor_sequencer: directed scenarios plus a random
// command stream compared against a queue-based schedule model.
module tb_motor_sequencer;

  localparam int unsigned STEP = 4;
  localparam int unsigned TRN  = 3;

  logic clk;
  logic rst;
  motor_sequencer_if bus ();

  motor_sequencer #(.STEP_CYCLES(STEP), .TURN_CYCLES(TRN), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: one queue entry per upcoming cycle. 1=fwd drive, 2=turn drive,
  // 3=done after fwd, 4=done after turn; empty queue = idle.
  int         sched[$];
  logic       exp_ready, exp_busy, exp_done;
  logic [3:0] exp_mot;
  logic [1:0] exp_heading;
  logic [7:0] exp_count;

  function automatic logic [3:0] mot();
    return {bus.left_en, bus.left_dir, bus.right_en, bus.right_dir};
  endfunction

  task automatic model_update_outputs();
    int cur;
    cur = (sched.size() != 0) ? sched[0] : 0;
    exp_ready = (cur == 0);
    exp_busy  = (cur == 1 || cur == 2);
    exp_done  = (cur >= 3);
    exp_mot   = (cur == 1) ? 4'b1111 : (cur == 2) ? 4'b1110 : 4'b0000;
  endtask

  task automatic model_reset();
    sched.delete();
    exp_heading = 2'd0;
    exp_count   = 8'd0;
    model_update_outputs();
  endtask

  task automatic model_edge(input logic f, input logic t);
    if (sched.size() == 0) begin
      if (t) begin
        for (int i = 0; i < int'(TRN); i++) sched.push_back(2);
        sched.push_back(4);
      end else if (f) begin
        for (int i = 0; i < int'(STEP); i++) sched.push_back(1);
        sched.push_back(3);
      end
    end else begin
      void'(sched.pop_front());
      if (sched.size() != 0 && sched[0] == 3) exp_count = exp_count + 8'd1;
      if (sched.size() != 0 && sched[0] == 4) exp_heading = exp_heading + 2'd1;
    end
    model_update_outputs();
  endtask

  // Drive commands for one edge and sample 1 time unit after it
  task automatic tick(input logic f, input logic t);
    bus.front = f;
    bus.turn  = t;
    @(posedge clk);
    model_edge(f, t);
    #1;
  endtask

  task automatic do_reset();
    bus.front = 1'b0;
    bus.turn  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", bus.busy, bus.done); end
    checks++; if (mot() !== 4'b0000) begin errors++; $display("FAIL reset_motors: got %b want 0000", mot()); end
    checks++; if (bus.heading !== 2'd0 || bus.move_count !== 8'd0) begin errors++; $display("FAIL reset_state: heading %0d count %0d want 0 0", bus.heading, bus.move_count); end
  endtask

  task automatic test_forward();
    do_reset();
    tick(1'b1, 1'b0);
    for (int i = 0; i < int'(STEP); i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.ready !== 1'b0 || mot() !== 4'b1111 || bus.done !== 1'b0) begin
        errors++; $display("FAIL fwd_drive[%0d]: busy %b ready %b motors %b done %b want 1 0 1111 0", i, bus.busy, bus.ready, mot(), bus.done);
      end
      tick(1'b0, 1'b0);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || mot() !== 4'b0000 || bus.move_count !== 8'd1 || bus.heading !== 2'd0) begin
      errors++; $display("FAIL fwd_done: done %b busy %b motors %b count %0d heading %0d want 1 0 0000 1 0", bus.done, bus.busy, mot(), bus.move_count, bus.heading);
    end
    tick(1'b0, 1'b0);
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL fwd_ready_back: ready %b done %b want 1 0", bus.ready, bus.done);
    end
  endtask

  task automatic test_turns();
    logic [1:0] hseq [4];
    hseq = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int n = 0; n < 4; n++) begin
      tick(1'b0, 1'b1);
      for (int i = 0; i < int'(TRN); i++) begin
        checks++;
        if (bus.busy !== 1'b1 || mot() !== 4'b1110) begin
          errors++; $display("FAIL turn_drive[%0d.%0d]: busy %b motors %b want 1 1110", n, i, bus.busy, mot());
        end
        tick(1'b0, 1'b0);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.heading !== hseq[n] || bus.move_count !== 8'd0) begin
        errors++; $display("FAIL turn_done[%0d]: done %b heading %0d count %0d want 1 %0d 0", n, bus.done, bus.heading, bus.move_count, hseq[n]);
      end
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_priority();
    logic [1:0] h0;
    logic [7:0] c0;
    h0 = exp_heading;
    c0 = exp_count;
    tick(1'b1, 1'b1);
    checks++;
    if (mot() !== 4'b1110) begin errors++; $display("FAIL prio_motors: got %b want 1110", mot()); end
    repeat (TRN + 1) tick(1'b0, 1'b0);
    checks++;
    if (bus.heading !== h0 + 2'd1 || bus.move_count !== c0 || bus.ready !== 1'b1) begin
      errors++; $display("FAIL prio_result: heading %0d count %0d ready %b want %0d %0d 1", bus.heading, bus.move_count, bus.ready, h0 + 2'd1, c0);
    end
  endtask

  task automatic test_ignore_and_hold();
    int dones;
    logic [7:0] c0;
    logic [1:0] h0;
    do_reset();
    h0 = exp_heading;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b want 1", bus.done); end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.heading !== h0 || bus.move_count !== 8'd1) begin
      errors++; $display("FAIL ignore_result: ready %b busy %b heading %0d count %0d want 1 0 %0d 1", bus.ready, bus.busy, bus.heading, bus.move_count, h0);
    end
    c0 = bus.move_count;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0);
      if (bus.done === 1'b1) dones++;
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 2 || bus.move_count !== 8'd3) begin
      errors++; $display("FAIL hold_moves: dones %0d count %0d want 2 %0d", dones, bus.move_count, c0 + 8'd2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b0, 1'b1);
    repeat (TRN + 1) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if (mot() !== 4'b1111) begin errors++; $display("FAIL areset_pre: motors %b want 1111", mot()); end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (mot() !== 4'b0000 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL areset_motors: motors %b ready %b busy %b want 0000 1 0", mot(), bus.ready, bus.busy);
    end
    checks++;
    if (bus.heading !== 2'd0 || bus.move_count !== 8'd0) begin
      errors++; $display("FAIL areset_state: heading %0d count %0d want 0 0", bus.heading, bus.move_count);
    end
    #2;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.move_count !== 8'd0) begin
        errors++; $display("FAIL areset_after[%0d]: done %b ready %b count %0d want 0 1 0", i, bus.done, bus.ready, bus.move_count);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b0, 1'b1);
    repeat (TRN + 1) tick(1'b0, 1'b0);
    for (int m = 0; m < 256; m++) begin
      tick(1'b1, 1'b0);
      repeat (STEP + 1) tick(1'b0, 1'b0);
      if (m == 254) begin
        checks++;
        if (bus.move_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", bus.move_count); end
      end
    end
    checks++;
    if (bus.move_count !== 8'd0 || bus.heading !== 2'd1) begin
      errors++; $display("FAIL wrap_zero: count %0d heading %0d want 0 1", bus.move_count, bus.heading);
    end
  endtask

  task automatic test_random();
    logic f, t;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      f = ($urandom_range(0, 2) == 0);
      t = ($urandom_range(0, 4) == 0);
      tick(f, t);
      checks++;
      if (bus.ready !== exp_ready || bus.busy !== exp_busy || bus.done !== exp_done || mot() !== exp_mot ||
          bus.heading !== exp_heading || bus.move_count !== exp_count) begin
        errors++;
        $display("FAIL random[%0d]: got r%b b%b d%b m%b h%0d c%0d want r%b b%b d%b m%b h%0d c%0d", i,
                 bus.ready, bus.busy, bus.done, mot(), bus.heading, bus.move_count,
                 exp_ready, exp_busy, exp_done, exp_mot, exp_heading, exp_count);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.front = 1'b0;
    bus.turn  = 1'b0;
    model_reset();
    test_reset();
    test_forward();
    test_turns();
    test_priority();
    test_ignore_and_hold();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
